// File: rtl/multimode_timing_gen.sv
// Multimode video timing generator with shadow/active register banks.
// Shadow bank takes cfg writes; it is committed to the active bank at
// frame end, or every cycle while the generator is disabled.
// Optional line-compare interrupt: define MTG_LINEIRQ_EN.
// RST_* parameters set the reset timing of both banks (VGA 640x480 by default).
module multimode_timing_gen #(
  parameter int CNT_W        = 12,
  parameter int RST_H_ACTIVE = 640,
  parameter int RST_H_FP     = 16,
  parameter int RST_H_SYNC   = 96,
  parameter int RST_H_BP     = 48,
  parameter int RST_V_ACTIVE = 480,
  parameter int RST_V_FP     = 10,
  parameter int RST_V_SYNC   = 2,
  parameter int RST_V_BP     = 33
) (
  input  logic             clkPixel,
  input  logic             resetn,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             csync,
  output logic             blank,
  output logic             frameDrawn,
  output logic             lineIrq,
  output logic             cfg_pending,
  output logic             cfg_err
);
  // Sums of four fields need two extra bits.
  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] LIMIT = SW'(1) << CNT_W;
  // Field index: 0 active, 1 front porch, 2 sync, 3 back porch.
  localparam logic [3:0][CNT_W-1:0] RST_H = {CNT_W'(RST_H_BP), CNT_W'(RST_H_SYNC),
                                             CNT_W'(RST_H_FP), CNT_W'(RST_H_ACTIVE)};
  localparam logic [3:0][CNT_W-1:0] RST_V = {CNT_W'(RST_V_BP), CNT_W'(RST_V_SYNC),
                                             CNT_W'(RST_V_FP), CNT_W'(RST_V_ACTIVE)};

  logic [3:0][CNT_W-1:0] sh_h_q, sh_h_d, sh_v_q, sh_v_d;
  logic [3:0][CNT_W-1:0] act_h_q, act_h_d, act_v_q, act_v_d;
  logic [3:0][CNT_W-1:0] sh_hc, sh_vc;
  logic [2:0]            sh_ctrl_q, sh_ctrl_d, act_ctrl_q, act_ctrl_d;
  logic [CNT_W-1:0]      h_q, h_d, v_q, v_d;
  logic                  pend_q, pend_d, err_q, err_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d, csync_q, csync_d;
  logic                  blank_q, blank_d, frame_q, frame_d;
  logic                  en, h_last, v_last, commit, sh_ok;
  logic                  hs_in, vs_in, n_en;
`ifdef MTG_LINEIRQ_EN
  logic [CNT_W-1:0]      sh_lcmp_q, sh_lcmp_d, act_lcmp_q, act_lcmp_d;
  logic                  line_q, line_d;
`endif

  // Zero-length fields are promoted to one cycle/line.
  function automatic logic [3:0][CNT_W-1:0] clamp4(input logic [3:0][CNT_W-1:0] f);
    logic [3:0][CNT_W-1:0] r;
    for (int i = 0; i < 4; i++) r[i] = (f[i] == '0) ? CNT_W'(1) : f[i];
    return r;
  endfunction

  function automatic logic [SW-1:0] total4(input logic [3:0][CNT_W-1:0] f);
    return SW'(f[0]) + SW'(f[1]) + SW'(f[2]) + SW'(f[3]);
  endfunction

  // Shadow writes, frame-end commit and next counter position.
  always_comb begin
    sh_h_d    = sh_h_q;
    sh_v_d    = sh_v_q;
    sh_ctrl_d = sh_ctrl_q;
`ifdef MTG_LINEIRQ_EN
    sh_lcmp_d  = sh_lcmp_q;
    act_lcmp_d = act_lcmp_q;
`endif
    if (cfg_we) begin
      case (cfg_addr)
        4'd0, 4'd1, 4'd2, 4'd3: sh_h_d[cfg_addr[1:0]] = cfg_wdata;
        4'd4, 4'd5, 4'd6, 4'd7: sh_v_d[cfg_addr[1:0]] = cfg_wdata;
        4'd8:                   sh_ctrl_d = cfg_wdata[2:0];
`ifdef MTG_LINEIRQ_EN
        4'd9:                   sh_lcmp_d = cfg_wdata;
`endif
        default: ;
      endcase
    end
    sh_hc  = clamp4(sh_h_q);
    sh_vc  = clamp4(sh_v_q);
    sh_ok  = (total4(sh_hc) <= LIMIT) && (total4(sh_vc) <= LIMIT);
    en     = act_ctrl_q[0];
    h_last = SW'(h_q) == total4(act_h_q) - SW'(1);
    v_last = SW'(v_q) == total4(act_v_q) - SW'(1);
    commit = !en || (h_last && v_last);
    // The commit uses the shadow as it stood before this cycle's write.
    act_h_d    = act_h_q;
    act_v_d    = act_v_q;
    act_ctrl_d = act_ctrl_q;
    pend_d     = pend_q;
    err_d      = cfg_we ? 1'b0 : err_q;
    if (commit) begin
      if (sh_ok) begin
        act_h_d    = sh_hc;
        act_v_d    = sh_vc;
        act_ctrl_d = sh_ctrl_q;
`ifdef MTG_LINEIRQ_EN
        act_lcmp_d = sh_lcmp_q;
`endif
        pend_d     = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (cfg_we) pend_d = 1'b1;
    h_d = '0;
    v_d = '0;
    if (!commit) begin
      if (h_last) v_d = v_q + CNT_W'(1);
      else begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
      end
    end
  end

  // Decode the next position against the next active bank so the
  // registered outputs line up with the counters they accompany.
  always_comb begin
    n_en    = act_ctrl_d[0];
    hs_in   = n_en && (SW'(h_d) >= SW'(act_h_d[0]) + SW'(act_h_d[1])) &&
              (SW'(h_d) < SW'(act_h_d[0]) + SW'(act_h_d[1]) + SW'(act_h_d[2]));
    vs_in   = n_en && (SW'(v_d) >= SW'(act_v_d[0]) + SW'(act_v_d[1])) &&
              (SW'(v_d) < SW'(act_v_d[0]) + SW'(act_v_d[1]) + SW'(act_v_d[2]));
    hsync_d = act_ctrl_d[1] ? hs_in : !hs_in;
    vsync_d = act_ctrl_d[2] ? vs_in : !vs_in;
    csync_d = (!act_ctrl_d[1] && !act_ctrl_d[2]) ? (hsync_d ^ vsync_d) : (hsync_d | vsync_d);
    blank_d = !n_en || (h_d >= act_h_d[0]) || (v_d >= act_v_d[0]);
    frame_d = n_en && (h_d == '0) && (v_d == act_v_d[0]);
`ifdef MTG_LINEIRQ_EN
    line_d  = n_en && (h_d == '0) && (v_d == act_lcmp_d);
`endif
  end

  // All state: both banks, counters, status and registered outputs.
  always_ff @(posedge clkPixel or negedge resetn) begin
    if (!resetn) begin
      sh_h_q     <= RST_H;
      sh_v_q     <= RST_V;
      act_h_q    <= RST_H;
      act_v_q    <= RST_V;
      sh_ctrl_q  <= 3'b001;
      act_ctrl_q <= 3'b001;
      h_q        <= '0;
      v_q        <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      csync_q    <= 1'b0;
      blank_q    <= 1'b1;
      frame_q    <= 1'b0;
`ifdef MTG_LINEIRQ_EN
      sh_lcmp_q  <= '0;
      act_lcmp_q <= '0;
      line_q     <= 1'b0;
`endif
    end else begin
      sh_h_q     <= sh_h_d;
      sh_v_q     <= sh_v_d;
      act_h_q    <= act_h_d;
      act_v_q    <= act_v_d;
      sh_ctrl_q  <= sh_ctrl_d;
      act_ctrl_q <= act_ctrl_d;
      h_q        <= h_d;
      v_q        <= v_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      csync_q    <= csync_d;
      blank_q    <= blank_d;
      frame_q    <= frame_d;
`ifdef MTG_LINEIRQ_EN
      sh_lcmp_q  <= sh_lcmp_d;
      act_lcmp_q <= act_lcmp_d;
      line_q     <= line_d;
`endif
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign csync       = csync_q;
  assign blank       = blank_q;
  assign frameDrawn  = frame_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;
`ifdef MTG_LINEIRQ_EN
  assign lineIrq     = line_q;
`else
  assign lineIrq     = 1'b0;
`endif
endmodule

// File: tb/tb_multimode_timing_gen.sv
// Bench for multimode_timing_gen: a small-timing instance checked every
// cycle against a frame-level reference model, plus a default-timing
// instance checked over its first lines.
module tb_multimode_timing_gen;
  localparam int CNT_W = 12;
  localparam int SD[10] = '{8, 2, 3, 2, 4, 1, 1, 2, 1, 0};
`ifdef MTG_LINEIRQ_EN
  localparam int LI_EXP = 1;
`else
  localparam int LI_EXP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn, cfg_we;
  logic [3:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic [CNT_W-1:0] h_count, v_count, d0_h, d0_v;
  logic hsync, vsync, csync, blank, frameDrawn, lineIrq, cfg_pending, cfg_err;
  logic d0_hs, d0_vs, d0_cs, d0_bl, d0_fd, d0_li, d0_pend, d0_err;

  multimode_timing_gen #(.CNT_W(CNT_W), .RST_H_ACTIVE(8), .RST_H_FP(2), .RST_H_SYNC(3),
    .RST_H_BP(2), .RST_V_ACTIVE(4), .RST_V_FP(1), .RST_V_SYNC(1), .RST_V_BP(2)) dut (
    .clkPixel(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .h_count(h_count), .v_count(v_count), .hsync(hsync),
    .vsync(vsync), .csync(csync), .blank(blank), .frameDrawn(frameDrawn),
    .lineIrq(lineIrq), .cfg_pending(cfg_pending), .cfg_err(cfg_err));

  multimode_timing_gen #(.CNT_W(CNT_W)) d0 (
    .clkPixel(clk), .resetn(resetn), .cfg_we(1'b0), .cfg_addr(4'd0),
    .cfg_wdata('0), .h_count(d0_h), .v_count(d0_v), .hsync(d0_hs),
    .vsync(d0_vs), .csync(d0_cs), .blank(d0_bl), .frameDrawn(d0_fd),
    .lineIrq(d0_li), .cfg_pending(d0_pend), .cfg_err(d0_err));

  logic [31:0] dv, d0v;
  assign dv  = {h_count, v_count, hsync, vsync, csync, blank, frameDrawn, lineIrq, cfg_pending, cfg_err};
  assign d0v = {d0_h, d0_v, d0_hs, d0_vs, d0_cs, d0_bl, d0_fd, d0_li, d0_pend, d0_err};

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // ---------------- reference model (frame-level arithmetic) ----------------
  int m_act[10], m_shd[10];
  int m_h, m_v;
  bit m_pend, m_err, m_fresh;

  function automatic int htot(); return m_act[0] + m_act[1] + m_act[2] + m_act[3]; endfunction
  function automatic int vtot(); return m_act[4] + m_act[5] + m_act[6] + m_act[7]; endfunction

  task automatic m_reset();
    m_act = SD; m_shd = SD; m_h = 0; m_v = 0; m_pend = 0; m_err = 0; m_fresh = 1;
  endtask

  task automatic m_step(input bit we, input int addr, input int data);
    int old[10];
    bit en, commit;
    old = m_shd;
    en = (m_act[8] & 1) != 0;
    commit = !en || (m_h == htot() - 1 && m_v == vtot() - 1);
    if (we) begin
      if (addr < 10) m_shd[addr] = (addr == 8) ? (data & 7) : (data & 4095);
      m_pend = 1;
      m_err = 0;
    end
    if (commit) begin
      for (int i = 0; i < 8; i++) if (old[i] == 0) old[i] = 1;
      if (old[0] + old[1] + old[2] + old[3] <= 4096 && old[4] + old[5] + old[6] + old[7] <= 4096) begin
        m_act = old;
        if (!we) m_pend = 0;
      end else m_err = 1;
      m_h = 0; m_v = 0;
    end else if (m_h == htot() - 1) begin
      m_h = 0; m_v++;
    end else m_h++;
    m_fresh = 0;
  endtask

  function automatic logic [31:0] m_out();
    bit en, ph, pv, hin, vin, hs, vs, cs, bl, fd, li;
    if (m_fresh) return {24'd0, 8'b0001_0000};
    en = (m_act[8] & 1) != 0; ph = (m_act[8] & 2) != 0; pv = (m_act[8] & 4) != 0;
    hin = en && m_h >= m_act[0] + m_act[1] && m_h < m_act[0] + m_act[1] + m_act[2];
    vin = en && m_v >= m_act[4] + m_act[5] && m_v < m_act[4] + m_act[5] + m_act[6];
    hs = ph ? hin : !hin;
    vs = pv ? vin : !vin;
    cs = (!ph && !pv) ? (hs ^ vs) : (hs | vs);
    bl = !en || m_h >= m_act[0] || m_v >= m_act[4];
    fd = en && m_h == 0 && m_v == m_act[4];
    li = (LI_EXP == 1) && en && m_h == 0 && m_v == m_act[9];
    return {12'(m_h), 12'(m_v), hs, vs, cs, bl, fd, li, m_pend, m_err};
  endfunction

  // ---------------- cycle driver ----------------
  bit d0_chk = 0;
  int d0n = 0;
  task automatic cyc(input bit we, input int addr, input int data);
    int h0;
    cfg_we = we; cfg_addr = 4'(addr); cfg_wdata = CNT_W'(data);
    @(posedge clk);
    m_step(we, addr, data);
    #1;
    cfg_we = 1'b0;
    check("outputs_vs_model", dv, m_out());
    if (d0_chk) begin
      d0n++;
      h0 = d0n % 800;
      check("default_timing", d0v, {12'(h0), 12'(d0n / 800), !(h0 >= 656 && h0 < 752), 1'b1,
            (h0 >= 656 && h0 < 752), (h0 >= 640), 4'b0000});
    end
  endtask

  task automatic wait_hv(input int hh, input int vv, input string nm);
    bit found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (h_count == CNT_W'(hh) && v_count == CNT_W'(vv)) found = 1;
      else cyc(0, 0, 0);
    end
    if (!found) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    int addr; int data; int exp_htot; int exp_hsw; bit exp_err;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hsw, fd_n, li_n;
    tbl[0] = '{0, 6,    13, 3, 0};
    tbl[1] = '{2, 0,    11, 1, 0};
    tbl[2] = '{0, 4095, 11, 1, 1};
    tbl[3] = '{0, 8,    13, 1, 0};
    tbl[4] = '{2, 3,    15, 3, 0};
    tbl[5] = '{13, 5,   15, 3, 0};
    tbl[6] = '{1, 0,    14, 3, 0};

    // Reset values on both instances.
    resetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut", dv, 32'h0000_0010);
    check("reset_d0", d0v, 32'h0000_0010);
    check("reset_model", dv, m_out());
    @(negedge clk) resetn = 1'b1;

    // Default VGA timing over the first two lines.
    d0_chk = 1;
    repeat (1700) cyc(0, 0, 0);
    d0_chk = 0;

    // Table: one write mid-frame, then measure the committed line.
    foreach (tbl[k]) begin
      wait_hv(2, v_count, "pre_write");
      cyc(1, tbl[k].addr, tbl[k].data);
      check("pending_after_write", 32'(cfg_pending), 32'd1);
      check("err_cleared_by_write", 32'(cfg_err), 32'd0);
      wait_hv(0, 0, "frame_end");
      check("pending_at_frame", 32'(cfg_pending), 32'(tbl[k].exp_err));
      check("err_at_frame", 32'(cfg_err), 32'(tbl[k].exp_err));
      n = 0; hsw = 0;
      do begin
        if (hsync == 1'b0) hsw++;
        n++;
        cyc(0, 0, 0);
      end while (h_count != '0 && n < 5000);
      check("line_total", 32'(n), 32'(tbl[k].exp_htot));
      check("hsync_width", 32'(hsw), 32'(tbl[k].exp_hsw));
    end

    // Write landing in the commit cycle stays pending.
    wait_hv(13, 7, "commit_cycle");
    cyc(1, 3, 4);
    check("commit_cycle_pos", {h_count, v_count}, 24'd0);
    check("commit_cycle_pending", 32'(cfg_pending), 32'd1);
    repeat (300) cyc(0, 0, 0);

    // Active-high syncs, OR csync, line compare at line 2.
    cyc(1, 9, 2);
    cyc(1, 8, 7);
    wait_hv(0, 0, "lcmp_a"); cyc(0, 0, 0);
    wait_hv(0, 0, "lcmp_b");
    fd_n = 0; li_n = 0;
    for (int i = 0; i < 16 * 8; i++) begin
      fd_n += int'(frameDrawn);
      li_n += int'(lineIrq);
      cyc(0, 0, 0);
    end
    check("frame_drawn_per_frame", 32'(fd_n), 32'd1);
    check("line_irq_per_frame", 32'(li_n), 32'(LI_EXP));

    // Disable: counters held, blanked, syncs idle; re-enable restarts at (0,0).
    cyc(1, 8, 0);
    repeat (200) cyc(0, 0, 0);
    check("disabled_state", {h_count, v_count, hsync, vsync, blank}, {24'd0, 3'b111});
    cyc(1, 8, 1);
    cyc(0, 0, 0);
    check("reenable_start", {h_count, v_count}, 24'd0);
    cyc(0, 0, 0);
    check("reenable_count", 32'(h_count), 32'd1);

    // Randomized configuration traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        int a, d;
        a = $urandom_range(0, 11);
        if (a == 8) d = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 7) | 1) : $urandom_range(0, 7);
        else if ($urandom_range(0, 31) == 0) d = 4095;
        else d = $urandom_range(0, 5);
        cyc(1, a, d);
      end else cyc(0, 0, 0);
    end

    // Reset mid-frame with a pending write.
    cyc(1, 8, 1);
    cyc(1, 4, 3);
    repeat (5) cyc(0, 0, 0);
    resetn = 1'b0;
    m_reset();
    #2;
    check("midframe_reset", dv, 32'h0000_0010);
    @(negedge clk) resetn = 1'b1;
    repeat (300) cyc(0, 0, 0);
    check("pending_lost", 32'(cfg_pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multimode_timing_gen.md
MULTIMODE_TIMING_GEN -- requirements
Module: multimode_timing_gen

Interface
REQ-001 Parameter CNT_W, default 12, width of counters, timing fields and cfg_wdata.
REQ-002 clkPixel  in  1  pixel clock; all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 cfg_we  in  1  register write strobe, one write per asserted cycle.
REQ-005 cfg_addr  in  4  register index: 0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_BP, 8 CTRL, 9 LINE_CMP; 10-15 ignored.
REQ-006 cfg_wdata  in  CNT_W  write data; CTRL uses bit0 enable, bit1 hsync polarity (1 = active-high), bit2 vsync polarity.
REQ-007 h_count, v_count  out  CNT_W each  pixel and line position, blanking included.
REQ-008 hsync, vsync, csync, blank  out  1 each  video timing signals.
REQ-009 frameDrawn  out  1  one-cycle interrupt pulse.
REQ-010 lineIrq  out  1  one-cycle line-compare pulse.
REQ-011 cfg_pending, cfg_err  out  1 each  shadow-bank status.

Function
REQ-012 Two register banks: cfg writes go to the shadow bank only; counters and decode use the active bank.
REQ-013 Line order: active, front porch, sync, back porch; H_TOTAL = sum of the four H fields; V_TOTAL = sum of the four V fields.
REQ-014 h_count increments each cycle and wraps to 0 after H_TOTAL-1; at wrap, v_count increments and wraps to 0 after V_TOTAL-1.
REQ-015 blank = 1 when h_count >= H_ACTIVE or v_count >= V_ACTIVE.
REQ-016 hsync asserted (at the CTRL polarity) when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on v_count with the V fields.
REQ-017 csync = hsync XOR vsync when both are active-low, else hsync OR vsync.
REQ-018 hsync, vsync, csync and blank are registered and correspond to the h_count/v_count value presented in the same cycle.
REQ-019 frameDrawn pulses for exactly the cycle where h_count = 0 and v_count = V_ACTIVE.
REQ-020 Any cfg write sets cfg_pending to 1.
REQ-021 Commit occurs on the cycle h_count = H_TOTAL-1 and v_count = V_TOTAL-1: the shadow bank is copied to active and cfg_pending is cleared; the next cycle is (0,0) under the new timing.
REQ-022 Commit check: any timing field equal to 0 is clamped to 1; if H_TOTAL or V_TOTAL exceeds 2^CNT_W, the commit is rejected, the active bank is kept, cfg_pending stays 1, and cfg_err is set.
REQ-023 cfg_err clears on the next cfg write.
REQ-024 A write in the commit cycle is excluded from that commit: it lands in the shadow bank and leaves cfg_pending = 1.
REQ-025 While active CTRL.enable = 0: counters are held at 0, blank = 1, syncs are inactive, frameDrawn and lineIrq are 0, and a commit occurs every cycle.
REQ-026 Writing enable = 1 while disabled therefore takes effect on the next cycle, with counting starting at (0,0).

Reset
REQ-027 resetn low: h_count = 0, v_count = 0, blank = 1, hsync = vsync = csync = 0, frameDrawn = lineIrq = 0, cfg_pending = cfg_err = 0.
REQ-028 Both banks reset to H 640/16/96/48, V 480/10/2/33, CTRL = 3'b001 (enabled, active-low syncs), LINE_CMP = 0.
REQ-029 Reset asserted mid-frame aborts the frame and discards any pending shadow writes; on release, counting restarts at (0,0).

Configuration
REQ-030 Macro MTG_LINEIRQ_EN defined: lineIrq pulses for the cycle where h_count = 0 and v_count = LINE_CMP (active bank), including LINE_CMP >= V_ACTIVE.
REQ-031 MTG_LINEIRQ_EN not defined: LINE_CMP writes are accepted and ignored, lineIrq is tied to 0, and the comparator logic is absent.

Verification
REQ-032 Reset, then run 2 frames with defaults -> H_TOTAL 800, V_TOTAL 525; hsync low for h_count 656-751; vsync low for v_count 490-491; one frameDrawn at (0,480) per frame.
REQ-033 Mid-frame, write H_ACTIVE = 320 -> cfg_pending = 1 and old timing until the frame ends; from the next (0,0), H_TOTAL = 480 and cfg_pending = 0.
REQ-034 Write H_SYNC = 0 -> committed as 1, giving a single-cycle hsync pulse per line.
REQ-035 With CNT_W = 12, write H_ACTIVE = 4000 -> at frame end, cfg_err = 1, timing unchanged; next write clears cfg_err.
REQ-036 CTRL = 3'b111 with LINE_CMP = 100, MTG_LINEIRQ_EN defined -> active-high syncs, csync = OR, one lineIrq per frame at (0,100); with the macro undefined, lineIrq stays 0.
REQ-037 Assert resetn low at (300,200) with a write pending -> all outputs at reset values; pending write lost; defaults restored on release.
